pmu_cmd_ctrl: RTL and testbench

Upstream command stage for `power_manager`. It decodes CPU writes on the 8080 I/O bus into single-cycle level-change and power-mode pulses, and it runs an idle timer that puts the system to sleep automatically. It also wakes the system on an external event. The block runs on the always-on board clock, so it keeps working while power domain 0 (the CPU) is gated off.

---
 rtl/pmu_pkg.sv | 33 +++
 rtl/pmu_idle_timer.sv | 40 ++++
 rtl/pmu_cmd_ctrl.sv | 155 +++++++++++++++
 tb/tb_pmu_cmd_ctrl.sv | 283 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pmu_pkg.sv
// ============================================================================
// Module   : pmu_pkg
// Purpose  : Shared opcodes, FSM encoding and status layout for pmu_cmd_ctrl.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

package pmu_pkg;

    localparam logic [1:0] OP_LEVEL   = 2'b00;
    localparam logic [1:0] OP_SLEEP   = 2'b01;
    localparam logic [1:0] OP_WAKE    = 2'b10;
    localparam logic [1:0] OP_TIMEOUT = 2'b11;

    localparam logic [7:0] PMU_PORT_DEFAULT = 8'h10;

    localparam logic MODE_RUN   = 1'b0;
    localparam logic MODE_SLEEP = 1'b1;

    localparam int STAT_ASLEEP_BIT  = 7;
    localparam int STAT_BUSY_BIT    = 6;
    localparam int STAT_TIMEOUT_MSB = 5;

    typedef enum logic [1:0] {
        ST_AWAKE  = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_SETTLE = 2'd2,
        ST_ASLEEP = 2'd3
    } pmu_state_e;

endpackage

`default_nettype wire

// File: rtl/pmu_idle_timer.sv
// ============================================================================
// Module   : pmu_idle_timer
// Purpose  : Saturating idle counter with expiry compare for auto-sleep.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmu_idle_timer
    import pmu_pkg::*;
#(
    parameter int TIMEOUT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 enable,
    input  logic                 clear,
    input  logic                 activity,
    input  logic [TIMEOUT_W-1:0] timeout,
    output logic                 expire
);

    logic [TIMEOUT_W-1:0] r_count;
    logic                 w_active;

    assign w_active = enable && (timeout != '0);

    // Any reason not to count also forces the counter back to zero.
    always_ff @(posedge clk) begin
        if (reset || clear || !w_active || activity) begin
            r_count <= '0;
        end else if (r_count != '1) begin
            r_count <= r_count + 1'b1;
        end
    end

    assign expire = w_active && (r_count == timeout);

endmodule

`default_nettype wire

// File: rtl/pmu_cmd_ctrl.sv
// ============================================================================
// Module   : pmu_cmd_ctrl
// Purpose  : Decodes I/O-port PMU commands into pulses; idle auto-sleep/wake.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module pmu_cmd_ctrl
    import pmu_pkg::*;
#(
    parameter logic [7:0] PMU_PORT      = PMU_PORT_DEFAULT,
    parameter int         SETTLE_CYCLES = 4,
    parameter int         TIMEOUT_W     = 16
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       io_wr,
    input  logic       io_rd,
    input  logic [7:0] io_addr,
    input  logic [7:0] io_wdata,
    output logic [7:0] io_rdata,
    input  logic       activity,
    input  logic       wake_event,
    output logic       change_level_flag,
    output logic [2:0] change_level,
    output logic       change_power_mode_flag,
    output logic       change_power_mode,
    output logic       asleep,
    output logic       cmd_drop
);

    localparam int SETTLE_W = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES + 1);

    pmu_state_e           r_state, w_state_nxt;
    logic [SETTLE_W-1:0]  r_settle_cnt;
    logic [TIMEOUT_W-1:0] r_timeout;
    logic                 r_last_sleep;
    logic                 w_wr_valid, w_rd_valid, w_expire, w_busy;
    logic                 w_issue, w_drop;
    logic [1:0]           w_op, w_issue_op;
    logic [7:0]           w_status;

    assign w_wr_valid = io_wr && (io_addr == PMU_PORT);
    assign w_rd_valid = io_rd && (io_addr == PMU_PORT);
    assign w_op       = io_wdata[7:6];
    assign w_busy     = (r_state == ST_ISSUE) || (r_state == ST_SETTLE);

    pmu_idle_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_idle_timer (
        .clk      (clk),
        .reset    (reset),
        .enable   (r_state == ST_AWAKE),
        .clear    (w_wr_valid),
        .activity (activity),
        .timeout  (r_timeout),
        .expire   (w_expire)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_issue     = 1'b0;
        w_issue_op  = OP_LEVEL;
        w_drop      = 1'b0;
        case (r_state)
            ST_AWAKE: begin
                // A write in the expiry cycle takes priority over auto-sleep.
                if (w_wr_valid) begin
                    if (w_op != OP_TIMEOUT) begin
                        w_state_nxt = ST_ISSUE;
                        w_issue     = 1'b1;
                        w_issue_op  = w_op;
                    end
                end else if (w_expire) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                    w_issue_op  = OP_SLEEP;
                end
            end
            ST_ISSUE: begin
                w_state_nxt = ST_SETTLE;
                w_drop      = w_wr_valid && (w_op != OP_TIMEOUT);
            end
            ST_SETTLE: begin
                w_drop = w_wr_valid && (w_op != OP_TIMEOUT);
                if (r_settle_cnt <= SETTLE_W'(1)) begin
                    w_state_nxt = r_last_sleep ? ST_ASLEEP : ST_AWAKE;
                end
            end
            ST_ASLEEP: begin
                if (wake_event || (w_wr_valid && (w_op == OP_WAKE))) begin
                    w_state_nxt = ST_ISSUE;
                    w_issue     = 1'b1;
                    w_issue_op  = OP_WAKE;
                end else begin
                    w_drop = w_wr_valid && (w_op != OP_TIMEOUT);
                end
            end
            default: w_state_nxt = ST_AWAKE;
        endcase
    end

    always_comb begin
        w_status                              = '0;
        w_status[STAT_ASLEEP_BIT]             = (r_state == ST_ASLEEP);
        w_status[STAT_BUSY_BIT]               = w_busy;
        w_status[STAT_TIMEOUT_MSB -: 6]       = r_timeout[TIMEOUT_W-1 -: 6];
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state                <= ST_AWAKE;
            r_settle_cnt           <= '0;
            r_timeout              <= '0;
            r_last_sleep           <= 1'b0;
            change_level_flag      <= 1'b0;
            change_level           <= 3'b000;
            change_power_mode_flag <= 1'b0;
            change_power_mode      <= MODE_RUN;
            asleep                 <= 1'b0;
            cmd_drop               <= 1'b0;
            io_rdata               <= 8'h00;
        end else begin
            r_state                <= w_state_nxt;
            change_level_flag      <= w_issue && (w_issue_op == OP_LEVEL);
            change_power_mode_flag <= w_issue && (w_issue_op != OP_LEVEL);
            asleep                 <= (w_state_nxt == ST_ASLEEP);
            cmd_drop               <= w_drop;
            io_rdata               <= w_rd_valid ? w_status : 8'h00;

            if (w_issue) begin
                r_last_sleep <= (w_issue_op == OP_SLEEP);
                if (w_issue_op == OP_LEVEL) begin
                    change_level <= io_wdata[2:0];
                end else begin
                    change_power_mode <= (w_issue_op == OP_SLEEP) ? MODE_SLEEP : MODE_RUN;
                end
            end

            if (r_state == ST_ISSUE) begin
                r_settle_cnt <= SETTLE_W'(SETTLE_CYCLES);
            end else if ((r_state == ST_SETTLE) && (r_settle_cnt != '0)) begin
                r_settle_cnt <= r_settle_cnt - 1'b1;
            end

            // Timeout updates are accepted in every state.
            if (w_wr_valid && (w_op == OP_TIMEOUT)) begin
                r_timeout <= {io_wdata[5:0], {(TIMEOUT_W-6){1'b0}}};
            end
        end
    end

endmodule

`default_nettype wire

// File: tb/tb_pmu_cmd_ctrl.sv
// ============================================================================
// Module   : tb_pmu_cmd_ctrl
// Purpose  : Self-checking bench: command table, pulse scoreboard, corner cases.
// Revision : 1.0 - initial release
// ============================================================================
`default_nettype none

module tb_pmu_cmd_ctrl;

    logic       clk = 1'b0;
    logic       reset, io_wr, io_rd, activity, wake_event;
    logic [7:0] io_addr, io_wdata, io_rdata;
    logic       change_level_flag, change_power_mode_flag, change_power_mode;
    logic       asleep, cmd_drop;
    logic [2:0] change_level;

    int checks = 0;
    int errors = 0;

    typedef struct packed {
        logic       lvl;
        logic [2:0] level;
        logic       mode;
    } exp_t;

    typedef struct {
        logic [7:0] addr;
        logic [7:0] wdata;
        int         kind;     // 0 none, 1 level pulse, 2 mode pulse
        logic [2:0] exp_level;
        logic       exp_mode;
    } vec_t;

    exp_t exp_q[$];

    pmu_cmd_ctrl dut (
        .clk                    (clk),
        .reset                  (reset),
        .io_wr                  (io_wr),
        .io_rd                  (io_rd),
        .io_addr                (io_addr),
        .io_wdata               (io_wdata),
        .io_rdata               (io_rdata),
        .activity               (activity),
        .wake_event             (wake_event),
        .change_level_flag      (change_level_flag),
        .change_level           (change_level),
        .change_power_mode_flag (change_power_mode_flag),
        .change_power_mode      (change_power_mode),
        .asleep                 (asleep),
        .cmd_drop               (cmd_drop)
    );

    always #5 clk = ~clk;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wr_cmd(input logic [7:0] addr, input logic [7:0] data);
        io_wr    = 1'b1;
        io_addr  = addr;
        io_wdata = data;
        tick();
        io_wr    = 1'b0;
    endtask

    task automatic push_exp(input logic lvl, input logic [2:0] level, input logic mode);
        exp_t e;
        e.lvl   = lvl;
        e.level = level;
        e.mode  = mode;
        exp_q.push_back(e);
    endtask

    task automatic chk_reset_outputs(input string tag);
        chk({tag, "_lvl_flag"},  32'(change_level_flag), 0);
        chk({tag, "_mode_flag"}, 32'(change_power_mode_flag), 0);
        chk({tag, "_level"},     32'(change_level), 0);
        chk({tag, "_mode"},      32'(change_power_mode), 0);
        chk({tag, "_asleep"},    32'(asleep), 0);
        chk({tag, "_rdata"},     32'(io_rdata), 0);
        chk({tag, "_drop"},      32'(cmd_drop), 0);
    endtask

    // Scoreboard: every flag pulse must match the oldest outstanding expectation.
    always @(posedge clk) begin
        #1;
        if (change_level_flag || change_power_mode_flag) begin
            if (exp_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL sb_unexpected: lvl_flag=%0b mode_flag=%0b with no pulse expected",
                         change_level_flag, change_power_mode_flag);
            end else begin
                exp_t e;
                e = exp_q.pop_front();
                chk("sb_lvl_flag",  32'(change_level_flag), 32'(e.lvl));
                chk("sb_mode_flag", 32'(change_power_mode_flag), 32'(!e.lvl));
                chk("sb_level",     32'(change_level), 32'(e.level));
                chk("sb_mode",      32'(change_power_mode), 32'(e.mode));
            end
        end
    end

    initial begin
        vec_t vecs[5];
        int   n;
        int   busy_cnt;

        vecs[0] = '{8'h10, 8'h03, 1, 3'd3, 1'b0};
        vecs[1] = '{8'h11, 8'h05, 0, 3'd3, 1'b0};
        vecs[2] = '{8'h10, 8'h3D, 1, 3'd5, 1'b0};
        vecs[3] = '{8'h10, 8'h81, 2, 3'd5, 1'b0};
        vecs[4] = '{8'h10, 8'h07, 1, 3'd7, 1'b0};

        reset = 1'b1; io_wr = 1'b0; io_rd = 1'b0; io_addr = 8'h00; io_wdata = 8'h00;
        activity = 1'b0; wake_event = 1'b0;
        tick(); tick();
        chk_reset_outputs("rst");
        reset = 1'b0;

        // SET_LEVEL 6 with status polled every cycle to measure busy length.
        push_exp(1'b1, 3'b110, 1'b0);
        io_rd = 1'b1;
        wr_cmd(8'h10, 8'h06);
        busy_cnt = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (io_rdata[6]) busy_cnt++;
        end
        io_rd = 1'b0;
        chk("busy_cycles", 32'(busy_cnt), 5);
        chk("level_6", 32'(change_level), 32'd6);

        for (int i = 0; i < 5; i++) begin
            if (vecs[i].kind == 1) push_exp(1'b1, vecs[i].exp_level, vecs[i].exp_mode);
            if (vecs[i].kind == 2) push_exp(1'b0, vecs[i].exp_level, vecs[i].exp_mode);
            wr_cmd(vecs[i].addr, vecs[i].wdata);
            repeat (8) tick();
            chk($sformatf("vec%0d_level", i), 32'(change_level), 32'(vecs[i].exp_level));
            chk($sformatf("vec%0d_mode", i), 32'(change_power_mode), 32'(vecs[i].exp_mode));
            chk($sformatf("vec%0d_q", i), 32'(exp_q.size()), 0);
        end

        // SLEEP: status during settle, asleep timing, status when asleep.
        push_exp(1'b0, 3'd7, 1'b1);
        wr_cmd(8'h10, 8'h40);
        io_rd = 1'b1; io_addr = 8'h10;
        tick();
        io_rd = 1'b0;
        chk("status_settle", 32'(io_rdata), 32'h40);
        n = 1;
        while (!asleep && n < 20) begin
            tick();
            n++;
        end
        chk("asleep_delay", 32'(n), 5);
        io_rd = 1'b1;
        tick();
        io_rd = 1'b0;
        chk("status_asleep", 32'(io_rdata), 32'h80);

        // Non-wake command while asleep is discarded.
        wr_cmd(8'h10, 8'h01);
        repeat (3) tick();
        chk("asleep_hold", 32'(asleep), 1);
        chk("asleep_level", 32'(change_level), 32'd7);

        // One-cycle wake_event.
        push_exp(1'b0, 3'd7, 1'b0);
        wake_event = 1'b1;
        tick();
        wake_event = 1'b0;
        chk("wake_flag", 32'(change_power_mode_flag), 1);
        chk("wake_asleep_fall", 32'(asleep), 0);
        repeat (8) tick();

        // Sleep again, then wake_event + WAKE write together, wake held long.
        push_exp(1'b0, 3'd7, 1'b1);
        wr_cmd(8'h10, 8'h40);
        repeat (8) tick();
        push_exp(1'b0, 3'd7, 1'b0);
        wake_event = 1'b1;
        wr_cmd(8'h10, 8'h80);
        repeat (12) tick();
        wake_event = 1'b0;
        chk("dual_wake_asleep", 32'(asleep), 0);
        chk("dual_wake_q", 32'(exp_q.size()), 0);

        // Drop during ISSUE, timeout applied during SETTLE, reset mid-SETTLE.
        push_exp(1'b1, 3'd2, 1'b0);
        wr_cmd(8'h10, 8'h02);
        wr_cmd(8'h10, 8'h01);
        chk("drop_pulse", 32'(cmd_drop), 1);
        chk("drop_level", 32'(change_level), 32'd2);
        wr_cmd(8'h10, 8'hC5);
        chk("timeout_no_drop", 32'(cmd_drop), 0);
        io_rd = 1'b1;
        tick();
        io_rd = 1'b0;
        chk("status_timeout", 32'(io_rdata), 32'h45);
        reset = 1'b1;
        tick();
        chk_reset_outputs("midreset");
        reset = 1'b0;
        io_rd = 1'b1;
        tick();
        io_rd = 1'b0;
        chk("status_after_reset", 32'(io_rdata), 32'h00);
        chk("midreset_q", 32'(exp_q.size()), 0);

        // Auto-sleep after 1024 idle cycles.
        push_exp(1'b0, 3'd0, 1'b1);
        wr_cmd(8'h10, 8'hC1);
        n = 0;
        while (!change_power_mode_flag && n < 1100) begin
            tick();
            n++;
        end
        chk("idle_expiry", 32'(n), 1025);
        repeat (8) tick();
        push_exp(1'b0, 3'd0, 1'b0);
        wake_event = 1'b1;
        tick();
        wake_event = 1'b0;
        repeat (6) tick();

        // Activity at cycle 1000 restarts the idle count.
        push_exp(1'b0, 3'd0, 1'b1);
        wr_cmd(8'h10, 8'hC1);
        repeat (999) tick();
        activity = 1'b1;
        tick();
        activity = 1'b0;
        n = 0;
        while (!change_power_mode_flag && n < 1100) begin
            tick();
            n++;
        end
        chk("idle_activity", 32'(1000 + n), 2025);
        repeat (8) tick();
        push_exp(1'b0, 3'd0, 1'b0);
        wake_event = 1'b1;
        tick();
        wake_event = 1'b0;
        repeat (6) tick();

        // Write on the expiry cycle wins over auto-sleep.
        push_exp(1'b1, 3'd2, 1'b0);
        wr_cmd(8'h10, 8'hC1);
        repeat (1024) tick();
        wr_cmd(8'h10, 8'h02);
        chk("expiry_write_lvl_flag", 32'(change_level_flag), 1);
        chk("expiry_write_mode_flag", 32'(change_power_mode_flag), 0);
        repeat (8) tick();
        wr_cmd(8'h10, 8'hC0);
        repeat (4) tick();
        chk("expiry_write_awake", 32'(asleep), 0);
        chk("final_q", 32'(exp_q.size()), 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

`default_nettype wire
